// File: rtl/vdp_io_port.sv
// CPU-facing I/O front end of the VDP: decodes Z80 data/control port accesses
// into VRAM requests, register writes and CRAM writes.
module vdp_io_port #(
  parameter int ADDR_W = 14,
  parameter int RD_LAT = 2
) (
  input  logic              clk_100,
  input  logic              rst_L,
  input  logic [7:0]        cpu_data_in,
  input  logic              cpu_port_sel,
  input  logic              cpu_wr,
  input  logic              cpu_rd,
  output logic [7:0]        cpu_data_out,
  output logic              cpu_busy,
  output logic [ADDR_W-1:0] io_addr,
  output logic [7:0]        io_wdata,
  output logic              io_we,
  output logic              io_re,
  input  logic              vram_grant,
  input  logic [7:0]        io_data_out,
  output logic              reg_we,
  output logic [3:0]        reg_idx,
  output logic [7:0]        reg_data,
  output logic              cram_we,
  output logic [4:0]        cram_addr,
  output logic [7:0]        cram_data,
  input  logic [7:0]        status_in,
  output logic              status_rd
);

  localparam int CNT_W = $clog2(RD_LAT + 1) + 1;

  typedef enum logic [1:0] {IDLE, WR_REQ, RD_REQ, RD_WAIT} state_t;

  state_t            state_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [1:0]        code_reg;
  logic              latch_first_reg;
  logic [7:0]        rbuf_reg;
  logic [CNT_W-1:0]  cnt_reg;

  // rbuf doubles as the write-data latch: a data write always loads it first.
  assign io_addr  = addr_reg;
  assign io_wdata = rbuf_reg;
  assign io_we    = (state_reg == WR_REQ);
  assign io_re    = (state_reg == RD_REQ);
  assign cpu_busy = (state_reg != IDLE);

  always_ff @(posedge clk_100 or negedge rst_L) begin
    if (!rst_L) begin
      state_reg       <= IDLE;
      addr_reg        <= '0;
      code_reg        <= 2'd0;
      latch_first_reg <= 1'b0;
      rbuf_reg        <= 8'h00;
      cnt_reg         <= '0;
      cpu_data_out    <= 8'h00;
      reg_we          <= 1'b0;
      reg_idx         <= 4'h0;
      reg_data        <= 8'h00;
      cram_we         <= 1'b0;
      cram_addr       <= 5'h00;
      cram_data       <= 8'h00;
      status_rd       <= 1'b0;
    end else begin
      reg_we    <= 1'b0;
      cram_we   <= 1'b0;
      status_rd <= 1'b0;

      // Status reads are serviced in every state; a concurrent write wins.
      if (!cpu_wr && cpu_rd && cpu_port_sel) begin
        cpu_data_out    <= status_in;
        status_rd       <= 1'b1;
        latch_first_reg <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          if (cpu_wr && cpu_port_sel) begin
            if (!latch_first_reg) begin
              addr_reg[7:0]   <= cpu_data_in;
              latch_first_reg <= 1'b1;
            end else begin
              latch_first_reg       <= 1'b0;
              code_reg              <= cpu_data_in[7:6];
              addr_reg[ADDR_W-1:8]  <= cpu_data_in[ADDR_W-9:0];
              case (cpu_data_in[7:6])
                2'd0: state_reg <= RD_REQ;
                2'd2: begin
                  reg_we   <= 1'b1;
                  reg_idx  <= cpu_data_in[3:0];
                  reg_data <= addr_reg[7:0];
                end
                default: ;
              endcase
            end
          end else if (cpu_wr) begin
            latch_first_reg <= 1'b0;
            rbuf_reg        <= cpu_data_in;
            if (code_reg == 2'd3) begin
              cram_we   <= 1'b1;
              cram_addr <= addr_reg[4:0];
              cram_data <= cpu_data_in;
              addr_reg  <= addr_reg + ADDR_W'(1);
            end else begin
              state_reg <= WR_REQ;
            end
          end else if (cpu_rd && !cpu_port_sel) begin
            latch_first_reg <= 1'b0;
            cpu_data_out    <= rbuf_reg;
            state_reg       <= RD_REQ;
          end
        end
        WR_REQ: begin
          if (vram_grant) begin
            addr_reg  <= addr_reg + ADDR_W'(1);
            state_reg <= IDLE;
          end
        end
        RD_REQ: begin
          if (vram_grant) begin
            cnt_reg   <= CNT_W'(RD_LAT);
            state_reg <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          // Capture on the cycle the count reaches zero: RD_LAT cycles after grant.
          cnt_reg <= cnt_reg - CNT_W'(1);
          if (cnt_reg == CNT_W'(1)) begin
            rbuf_reg  <= io_data_out;
            addr_reg  <= addr_reg + ADDR_W'(1);
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/vdp_io_port.md
Name: vdp_io_port

Overview:
- CPU-facing I/O front end of the VDP. It decodes Z80 data-port and control-port accesses into VRAM read/write requests, VDP register writes and CRAM writes.
- Directly upstream of the VRAM block: it drives that block's io_addr, data_in, io_we and io_re, and consumes io_data_out.
- It maintains the 14-bit auto-incrementing VRAM address register, the two-byte control latch and the read-ahead buffer.

Parameters:
- ADDR_W, 14, VRAM address width; wraps at 2^ADDR_W.
- RD_LAT, 2, cycles from the vram_grant cycle to valid io_data_out.

Ports:
- clk_100  in  1  system clock.
- rst_L  in  1  async active-low reset.
- cpu_data_in  in  8  CPU write data.
- cpu_port_sel  in  1  0 = data port, 1 = control port.
- cpu_wr  in  1  one-cycle write strobe.
- cpu_rd  in  1  one-cycle read strobe.
- cpu_data_out  out  8  CPU read data; valid the cycle after cpu_rd.
- cpu_busy  out  1  VRAM transaction pending.
- io_addr  out  ADDR_W  VRAM address.
- io_wdata  out  8  VRAM write data; connects to the VRAM data_in.
- io_we  out  1  VRAM write request; level, held until grant.
- io_re  out  1  VRAM read request; level, held until grant.
- vram_grant  in  1  pulse in the cycle the VRAM services the io request.
- io_data_out  in  8  VRAM read data.
- reg_we  out  1  register write pulse.
- reg_idx  out  4  register index.
- reg_data  out  8  register value.
- cram_we  out  1  CRAM write pulse.
- cram_addr  out  5  CRAM address.
- cram_data  out  8  CRAM data.
- status_in  in  8  VDP status byte.
- status_rd  out  1  pulse; the status block clears its flags.

Behaviour:
- Reset: all outputs 0; addr = 0; code = 0; latch_first = 0; rbuf = 0; FSM in IDLE.

Control write:
- If latch_first = 0: store the byte in addr[7:0] and set latch_first.
- Otherwise: code = byte[7:6], addr[13:8] = byte[5:0], clear latch_first. Then, by code:
  - Code 0: start a read-ahead (enter RD_REQ); addr increments on completion.
  - Code 1: no action.
  - Code 2: reg_we pulse next cycle with reg_idx = byte[3:0] and reg_data = the first byte. addr and code remain updated.
  - Code 3: no action.

Control read:
- cpu_data_out = status_in, captured on the cpu_rd cycle.
- status_rd pulses for 1 cycle; latch_first is cleared.
- Permitted even while busy.

Data write:
- Clears latch_first; rbuf = byte.
- If code = 3: cram_we pulse next cycle, cram_addr = addr[4:0], cram_data = byte, addr increments; no VRAM access.
- Otherwise: enter WR_REQ.

Data read:
- Clears latch_first; cpu_data_out = rbuf.
- Then enter RD_REQ to refill rbuf from addr.

FSM:
- IDLE -> WR_REQ or RD_REQ on the triggers above.
- WR_REQ: io_we = 1, io_addr = addr, io_wdata = latched byte. On vram_grant: addr++ and go to IDLE.
- RD_REQ: io_re = 1, io_addr = addr. On vram_grant: go to RD_WAIT with the counter = RD_LAT.
- RD_WAIT: decrement the counter. At 0, rbuf = io_data_out, addr++, go to IDLE.
- io_we and io_re are never both high. Both deassert in the cycle after the grant.
- cpu_busy = (state != IDLE).

Increment and wrap:
- addr is ADDR_W bits; 0x3FFF + 1 = 0x0000.
- The CRAM increment uses the same register.

Strobes while busy:
- Data-port accesses and control writes are dropped with no state change. The CPU must poll cpu_busy.
- Control reads are serviced.

Simultaneous strobes:
- cpu_wr and cpu_rd in the same cycle: the write wins and the read is ignored.

Reset mid-transaction:
- Returns to IDLE immediately.
- io_we and io_re drop asynchronously.
- The pending access is lost.

Test Plan:
1. Control writes 0x34, then 0x52 (code 1, addr 0x1234). Data write 0xAB -> io_we high with io_addr 0x1234, io_wdata 0xAB. Grant in cycle 3 -> addr = 0x1235, cpu_busy low in cycle 4.
2. Control writes 0xFF, then 0x3F (code 0, addr 0x3FFF) -> io_re high with io_addr 0x3FFF. Grant; VRAM returns 0x5A RD_LAT=2 cycles later -> rbuf = 0x5A, addr wraps to 0x0000. Next data read -> cpu_data_out = 0x5A and io_re asserts at 0x0000.
3. Control writes 0x81, then 0x87 -> single reg_we pulse, reg_idx = 7, reg_data = 0x81; io_we/io_re stay low.
4. Control writes 0x00, then 0xC0; data writes 0x11 and 0x22 -> cram_we at cram_addr 0 then 1 with data 0x11/0x22; addr ends at 2; no VRAM access.
5. Control write 0x34, then control read with status_in = 0x80 -> cpu_data_out 0x80, status_rd pulse. A following control write 0x10 is treated as a first byte: addr[7:0] = 0x10, no code change.
6. Data write while WR_REQ is pending with no grant -> dropped; the addr and io_wdata of the original request are unchanged. rst_L low mid-RD_WAIT -> all outputs 0 and state IDLE.
